decode_s1_s2_pipe: RTL and testbench

Pipeline boundary between decode stage 1 and decode stage 2. It registers the packed stage-1 control bundle (size, D-flag controls, operand selects, ModR/M, SIB, imm, disp, ALU op, flag selects, stack op, segment override, PC, branch_taken) behind a two-entry skid buffer, so the `s1_ready` it returns never combinationally depends on stage 2's ready. It discards in-flight instructions on flush, supports a hold from the control unit, and reports occupancy and a saturating discard count for debug.

---
 rtl/decode_s1_s2_pipe.sv | 98 +++++++++
 tb/tb_decode_s1_s2_pipe.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/decode_s1_s2_pipe.sv
// Decode stage-1 to stage-2 pipeline boundary: a two-entry skid buffer whose upstream
// ready is a pure register output. It also handles flush and hold, and keeps a saturating discard count.
module decode_s1_s2_pipe #(
  parameter int WIDTH = 158,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             hold,
  input  logic             s1_valid,
  output logic             s1_ready,
  input  logic [WIDTH-1:0] s1_payload,
  output logic             s2_valid,
  input  logic             s2_ready,
  output logic [WIDTH-1:0] s2_payload,
  output logic [1:0]       occupancy,
  output logic [CNTW-1:0]  discard_cnt
);

  logic             main_v_q, main_v_d;
  logic             skid_v_q, skid_v_d;
  logic [WIDTH-1:0] main_d_q, main_d_d;
  logic [WIDTH-1:0] skid_d_q, skid_d_d;
  logic [CNTW-1:0]  discard_cnt_q, discard_cnt_d;

  logic             acc;
  logic             drn;
  logic [1:0]       discard_add;
  logic [CNTW+1:0]  discard_sum;

  // Upstream ready comes only from the skid flag, so it never depends on s2_ready or hold.
  assign s1_ready    = ~skid_v_q;
  assign s2_valid    = main_v_q & ~hold;
  assign s2_payload  = main_d_q;
  assign occupancy   = {1'b0, main_v_q} + {1'b0, skid_v_q};
  assign discard_cnt = discard_cnt_q;

  assign acc = s1_valid & s1_ready;
  assign drn = s2_valid & s2_ready;

  // An entry stage 2 consumes during the flush cycle is delivered, not discarded.
  // drn implies main_v_q, so this subtraction cannot go negative.
  assign discard_add = {1'b0, main_v_q} + {1'b0, skid_v_q} - {1'b0, drn};
  assign discard_sum = {2'b00, discard_cnt_q} + {{CNTW{1'b0}}, discard_add};

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    main_v_d      = main_v_q;
    skid_v_d      = skid_v_q;
    main_d_d      = main_d_q;
    skid_d_d      = skid_d_q;
    discard_cnt_d = discard_cnt_q;

    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
      if (discard_sum > {2'b00, {CNTW{1'b1}}}) begin
        discard_cnt_d = {CNTW{1'b1}};
      end else begin
        discard_cnt_d = discard_sum[CNTW-1:0];
      end
    end else if (skid_v_q) begin
      // The skid entry moves up only when main drains, which keeps the order FIFO.
      if (drn) begin
        main_d_d = skid_d_q;
        skid_v_d = 1'b0;
      end
    end else if (acc && (!main_v_q || drn)) begin
      main_d_d = s1_payload;
      main_v_d = 1'b1;
    end else if (acc) begin
      skid_d_d = s1_payload;
      skid_v_d = 1'b1;
    end else if (drn) begin
      main_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the payload registers are reset as well, so s2_payload reads 0 out of reset.
      main_v_q      <= 1'b0;
      skid_v_q      <= 1'b0;
      main_d_q      <= '0;
      skid_d_q      <= '0;
      discard_cnt_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples the pre-edge values.
      main_v_q      <= main_v_d;
      skid_v_q      <= skid_v_d;
      main_d_q      <= main_d_d;
      skid_d_q      <= skid_d_d;
      discard_cnt_q <= discard_cnt_d;
    end
  end

endmodule

// File: tb/tb_decode_s1_s2_pipe.sv
// Self-checking bench for decode_s1_s2_pipe: directed scenarios followed by random traffic.
// All of it is checked against a queue-based model of the buffer contents.
module tb_decode_s1_s2_pipe;
  localparam int WIDTH = 158;
  localparam int CNTW  = 2;
  localparam int CMAX  = 3;

  logic             clk = 1'b0;
  logic             reset, flush, hold, s1_valid, s1_ready, s2_valid, s2_ready;
  logic [WIDTH-1:0] s1_payload, s2_payload;
  logic [1:0]       occupancy;
  logic [CNTW-1:0]  discard_cnt;

  int total = 0;
  int bad   = 0;

  // Model: the queue holds the bundles held in the buffer, oldest first.
  logic [WIDTH-1:0] mq[$];
  int               mcnt = 0;

  decode_s1_s2_pipe #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset), .flush(flush), .hold(hold),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_payload(s1_payload),
    .s2_valid(s2_valid), .s2_ready(s2_ready), .s2_payload(s2_payload),
    .occupancy(occupancy), .discard_cnt(discard_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("s1_ready", WIDTH'(s1_ready), WIDTH'(mq.size() < 2));
    check("s2_valid", WIDTH'(s2_valid), WIDTH'(mq.size() > 0 && !hold));
    check("occupancy", WIDTH'(occupancy), WIDTH'(mq.size()));
    check("discard_cnt", WIDTH'(discard_cnt), WIDTH'(mcnt));
    if (mq.size() > 0) check("s2_payload", s2_payload, mq[0]);
  endtask

  // One clock: drive inputs, check outputs at the falling edge, advance the model, pass the rising edge.
  task automatic step(input logic v, input logic [WIDTH-1:0] p, input logic rdy,
                      input logic hld, input logic fl);
    logic acc, drn;
    s1_valid = v; s1_payload = p; s2_ready = rdy; hold = hld; flush = fl;
    @(negedge clk);
    check_outputs();
    acc = v && (mq.size() < 2);
    drn = (mq.size() > 0) && !hld && rdy;
    if (fl) begin
      mcnt = mcnt + mq.size() - int'(drn);
      if (mcnt > CMAX) mcnt = CMAX;
      mq.delete();
    end else begin
      if (drn) void'(mq.pop_front());
      if (acc) mq.push_back(p);
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] rand_payload();
    return WIDTH'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
  endfunction

  initial begin
    reset = 1'b1; flush = 1'b0; hold = 1'b0; s1_valid = 1'b0; s2_ready = 1'b0; s1_payload = '0;
    #1;
    check("rst_s1_ready", WIDTH'(s1_ready), WIDTH'(1));
    check("rst_s2_valid", WIDTH'(s2_valid), WIDTH'(0));
    check("rst_s2_payload", s2_payload, '0);
    check("rst_occupancy", WIDTH'(occupancy), WIDTH'(0));
    check("rst_discard", WIDTH'(discard_cnt), WIDTH'(0));
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // Streaming: 1..8 back to back, then drain.
    for (int i = 1; i <= 8; i++) step(1'b1, WIDTH'(i), 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Backpressure: A presented, stall, offer B and C.
    step(1'b1, WIDTH'(16'hA), 1'b1, 1'b0, 1'b0);
    step(1'b1, WIDTH'(16'hB), 1'b0, 1'b0, 1'b0);
    step(1'b1, WIDTH'(16'hC), 1'b0, 1'b0, 1'b0);
    step(1'b1, WIDTH'(16'hC), 1'b0, 1'b0, 1'b0);
    step(1'b1, WIDTH'(16'hC), 1'b1, 1'b0, 1'b0);
    step(1'b1, WIDTH'(16'hC), 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Hold with one entry, a second bundle is absorbed, then release.
    step(1'b1, WIDTH'(16'h11), 1'b1, 1'b0, 1'b0);
    step(1'b1, WIDTH'(16'h12), 1'b1, 1'b1, 1'b0);
    step(1'b1, WIDTH'(16'h13), 1'b1, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Flush while full with an upstream offer pending.
    step(1'b1, WIDTH'(16'h21), 1'b0, 1'b0, 1'b0);
    step(1'b1, WIDTH'(16'h22), 1'b0, 1'b0, 1'b0);
    step(1'b1, WIDTH'(16'h23), 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Flush together with a drain: the consumed entry is not counted.
    step(1'b1, WIDTH'(16'h31), 1'b1, 1'b0, 1'b0);
    step(1'b1, WIDTH'(16'h32), 1'b1, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Saturation: two more full flushes against a 2-bit counter.
    for (int k = 0; k < 2; k++) begin
      step(1'b1, WIDTH'(16'h41 + k), 1'b0, 1'b0, 1'b0);
      step(1'b1, WIDTH'(16'h51 + k), 1'b0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    end
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset between edges while full.
    step(1'b1, WIDTH'(16'h61), 1'b0, 1'b0, 1'b0);
    step(1'b1, WIDTH'(16'h62), 1'b0, 1'b0, 1'b0);
    s1_valid = 1'b0; s2_ready = 1'b0; hold = 1'b0; flush = 1'b0;
    #2;
    check("pre_arst_occupancy", WIDTH'(occupancy), WIDTH'(2));
    reset = 1'b1;
    #1;
    check("arst_s2_valid", WIDTH'(s2_valid), WIDTH'(0));
    check("arst_s1_ready", WIDTH'(s1_ready), WIDTH'(1));
    check("arst_discard", WIDTH'(discard_cnt), WIDTH'(0));
    check("arst_occupancy", WIDTH'(occupancy), WIDTH'(0));
    check("arst_s2_payload", s2_payload, '0);
    @(posedge clk); #1;
    reset = 1'b0;
    mq.delete();
    mcnt = 0;

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 3) != 0), rand_payload(), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 24) == 0));
    end
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
